// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding, digit limit and BCD range check for the nibble serializer
package bcd_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= DIGIT_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_clamp.sv
// bcd_digit_clamp: saturates a non-BCD nibble to 9 and flags it
module bcd_digit_clamp
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o,
  output logic       err_o
);
  assign err_o = !is_bcd(nib_i);
  assign nib_o = err_o ? DIGIT_MAX : nib_i;
endmodule

// File: rtl/bcd_nibble_serializer.sv
// bcd_nibble_serializer: word-in, one-BCD-digit-per-beat-out serializer with valid/ready on both sides
// Build option BCD_CLAMP_EN: clamp digits above 9 to 9 and raise err_digit for that beat.
module bcd_nibble_serializer
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter bit MSD_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3:0]          out_nibble,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                err_digit,
  output logic                busy
);
  localparam int W = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  state_e state_q, state_d;
  logic [W-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] nib_q, cur, nib;
  logic last_q, err_q, err, cap, acc;
  assign out_valid = state_q == SEND;
  assign busy = out_valid;
  assign acc = out_valid & out_ready;
  assign in_ready = (state_q == IDLE) | (acc & last_q);
  assign cap = in_valid & in_ready;
  always_comb begin
    sr_d = cap ? in_data : acc ? (MSD_FIRST ? sr_q << 4 : sr_q >> 4) : sr_q;
    idx_d = cap ? '0 : acc ? (idx_q == LAST_IDX ? '0 : idx_q + 1'b1) : idx_q;
    state_d = cap ? SEND : (acc & last_q) ? IDLE : state_q;
    cur = MSD_FIRST ? sr_d[W-1 -: 4] : sr_d[3:0];
  end
`ifdef BCD_CLAMP_EN
  bcd_digit_clamp u_clamp (.nib_i(cur), .nib_o(nib), .err_o(err));
`else
  assign nib = cur;
  assign err = 1'b0;
`endif
  // Output registers are recomputed from the next shift state, so a stall reproduces the same beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      nib_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      nib_q   <= nib;
      last_q  <= (state_d == SEND) & (idx_d == LAST_IDX);
      err_q   <= err & (state_d == SEND);
    end
  end
  assign out_nibble = nib_q;
  assign out_last = last_q;
  assign err_digit = err_q;
endmodule
